// File: rtl/wb_bus_intercon.sv
// Single-master, 16-slave Wishbone-style interconnect with address decode,
// read-data/ACK return mux and a watchdog that error-terminates hung cycles.

module wb_bus_intercon_port #(
  parameter logic [3:0] IDX = 4'd0
) (
  input  logic [3:0] sel,
  input  logic       en,
  input  logic       ack,
  output logic       stb,
  output logic       hit_ack
);
  logic hit;

  assign hit     = (sel == IDX);
  assign stb     = hit & en;
  assign hit_ack = hit & ack;
endmodule

module wb_bus_intercon #(
  parameter int          NUM_SLAVES = 16,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = 32'hDEADBEEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     master_STB,
  input  logic                     master_WE,
  input  logic [31:0]              master_ADDR,
  input  logic [31:0]              master_DAT_I,
  output logic [31:0]              master_DAT_O,
  output logic                     master_ACK,
  output logic                     master_ERR,
  output logic [NUM_SLAVES-1:0]    slave_STB,
  input  logic [NUM_SLAVES-1:0]    slave_ACK,
  output logic                     slave_WE,
  output logic [31:0]              slave_ADDR,
  output logic [31:0]              slave_DAT_O,
  input  logic [32*NUM_SLAVES-1:0] slave_DAT_I,
  output logic [31:0]              err_addr
);
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

  logic [3:0]            sel;
  logic                  en;
  logic [NUM_SLAVES-1:0] hit_ack;
  logic                  ack_sel;
  logic [15:0]           wd_cnt;
  logic                  err_pulse;
  logic                  blocked;
  logic                  err_now;

  assign sel = master_ADDR[31:28];
  assign en  = master_STB & ~blocked & ~rst;

  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_port
    wb_bus_intercon_port #(.IDX(4'(k))) u_port (
      .sel     (sel),
      .en      (en),
      .ack     (slave_ACK[k]),
      .stb     (slave_STB[k]),
      .hit_ack (hit_ack[k])
    );
  end

  assign ack_sel = |hit_ack;

  assign slave_ADDR  = master_ADDR;
  assign slave_DAT_O = master_DAT_I;
  assign slave_WE    = master_WE;

  // The registered error pulse is masked in a reset cycle so ACK drops with reset.
  assign err_now      = err_pulse & ~rst;
  assign master_ACK   = (en & ack_sel) | err_now;
  assign master_ERR   = err_now;
  assign master_DAT_O = err_now ? ERR_DATA : slave_DAT_I[{sel, 5'd0} +: 32];

  // Watchdog: a slave ACK on the timeout edge wins over the error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt    <= '0;
      err_pulse <= 1'b0;
      blocked   <= 1'b0;
      err_addr  <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (!master_STB) begin
        wd_cnt  <= '0;
        blocked <= 1'b0;
      end else if (blocked || ack_sel) begin
        wd_cnt <= '0;
      end else if (wd_cnt == WD_LAST) begin
        err_pulse <= 1'b1;
        blocked   <= 1'b1;
        err_addr  <= master_ADDR;
        wd_cnt    <= '0;
      end else begin
        wd_cnt <= wd_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_wb_bus_intercon.sv
// Randomized bench for wb_bus_intercon: per-cycle comparison against a
// transaction-level model (pending age / error termination) plus directed pins.

module tb_wb_bus_intercon;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         master_STB, master_WE;
  logic [31:0]  master_ADDR, master_DAT_I, master_DAT_O;
  logic         master_ACK, master_ERR;
  logic [15:0]  slave_STB, slave_ACK;
  logic         slave_WE;
  logic [31:0]  slave_ADDR, slave_DAT_O, err_addr;
  logic [511:0] slave_DAT_I;

  int n_total = 0;
  int n_pass  = 0;

  wb_bus_intercon #(.NUM_SLAVES(16), .TIMEOUT(TO), .ERR_DATA(32'hDEADBEEF)) dut (
    .clk          (clk),
    .rst          (rst),
    .master_STB   (master_STB),
    .master_WE    (master_WE),
    .master_ADDR  (master_ADDR),
    .master_DAT_I (master_DAT_I),
    .master_DAT_O (master_DAT_O),
    .master_ACK   (master_ACK),
    .master_ERR   (master_ERR),
    .slave_STB    (slave_STB),
    .slave_ACK    (slave_ACK),
    .slave_WE     (slave_WE),
    .slave_ADDR   (slave_ADDR),
    .slave_DAT_O  (slave_DAT_O),
    .slave_DAT_I  (slave_DAT_I),
    .err_addr     (err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // Transaction model: how long the current access has waited, and whether it
  // was already terminated by the watchdog (then silent until STB drops).
  int          age = 0;
  bit          ended = 0, err_cycle = 0, mvalid = 0;
  logic [31:0] m_err_addr = '0;
  int          s;
  bit          sel_ack;
  logic [15:0] e_stb;
  logic        e_ack, e_err;
  logic [31:0] e_dat, word;

  always @(negedge clk) begin
    s       = int'(master_ADDR[31:28]);
    sel_ack = slave_ACK[s];
    word    = slave_DAT_I[s*32 +: 32];
    if (rst) begin
      e_stb = '0; e_ack = 1'b0; e_err = 1'b0; e_dat = word;
    end else begin
      e_stb = (master_STB && !ended) ? 16'(1 << s) : 16'h0;
      e_err = err_cycle;
      e_ack = err_cycle | (master_STB && !ended && sel_ack);
      e_dat = err_cycle ? 32'hDEADBEEF : word;
    end
    if (mvalid) begin
      check("slave_STB",    {16'h0, slave_STB}, {16'h0, e_stb});
      check("master_ACK",   {31'h0, master_ACK}, {31'h0, e_ack});
      check("master_ERR",   {31'h0, master_ERR}, {31'h0, e_err});
      check("master_DAT_O", master_DAT_O, e_dat);
      check("err_addr",     err_addr, m_err_addr);
      check("slave_ADDR",   slave_ADDR, master_ADDR);
      check("slave_DAT_O",  slave_DAT_O, master_DAT_I);
      check("slave_WE",     {31'h0, slave_WE}, {31'h0, master_WE});
    end
    if (rst) begin
      age = 0; ended = 0; err_cycle = 0; m_err_addr = '0; mvalid = 1;
    end else begin
      err_cycle = 0;
      if (!master_STB) begin
        age = 0; ended = 0;
      end else if (!ended) begin
        if (sel_ack) age = 0;
        else begin
          age++;
          if (age == TO) begin
            err_cycle = 1; ended = 1; m_err_addr = master_ADDR; age = 0;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int  stuck;
  bit  done;

  initial begin
    rst = 1'b1; master_STB = 1'b0; master_WE = 1'b0; master_ADDR = '0;
    master_DAT_I = '0; slave_ACK = '0; slave_DAT_I = '0;
    tick(); tick();
    #1 check("rst_stb", {16'h0, slave_STB}, 32'h0);
    check("rst_ack", {31'h0, master_ACK}, 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    rst = 1'b0;

    // RAM read, slave 0 ACKs after 3 cycles
    tick();
    master_STB = 1'b1; master_ADDR = 32'h0000_0010; master_WE = 1'b0;
    repeat (3) tick();
    slave_DAT_I[31:0] = 32'h1234_5678; slave_ACK = 16'h0001;
    #1 check("ram_stb", {16'h0, slave_STB}, 32'h0000_0001);
    check("ram_ack", {31'h0, master_ACK}, 32'h1);
    check("ram_dat", master_DAT_O, 32'h1234_5678);
    check("ram_err", {31'h0, master_ERR}, 32'h0);
    tick(); master_STB = 1'b0; slave_ACK = '0;

    // Write to slave 4, immediate ACK
    tick();
    master_STB = 1'b1; master_ADDR = 32'h4000_0000; master_WE = 1'b1;
    master_DAT_I = 32'hCAFE_F00D; slave_ACK = 16'h0010;
    #1 check("wr_stb", {16'h0, slave_STB}, 32'h0000_0010);
    check("wr_we", {31'h0, slave_WE}, 32'h1);
    check("wr_dat", slave_DAT_O, 32'hCAFE_F00D);
    check("wr_ack", {31'h0, master_ACK}, 32'h1);
    tick(); master_STB = 1'b0; master_WE = 1'b0; slave_ACK = '0;

    // Unmapped slave 9 times out after exactly TO cycles
    tick();
    master_STB = 1'b1; master_ADDR = 32'h9000_0000;
    for (int i = 1; i < TO; i++) begin
      tick();
      #1 check("to_wait_ack", {31'h0, master_ACK}, 32'h0);
      check("to_wait_stb", {16'h0, slave_STB}, 32'h0000_0200);
    end
    tick();
    #1 check("to_ack", {31'h0, master_ACK}, 32'h1);
    check("to_err", {31'h0, master_ERR}, 32'h1);
    check("to_dat", master_DAT_O, 32'hDEADBEEF);
    check("to_err_addr", err_addr, 32'h9000_0000);
    check("to_stb", {16'h0, slave_STB}, 32'h0);
    tick();
    #1 check("blk_ack", {31'h0, master_ACK}, 32'h0);
    check("blk_stb", {16'h0, slave_STB}, 32'h0);
    master_STB = 1'b0;
    tick();
    master_STB = 1'b1; master_ADDR = 32'h0000_0100; slave_ACK = 16'h0001;
    #1 check("after_to_ack", {31'h0, master_ACK}, 32'h1);
    check("after_to_err", {31'h0, master_ERR}, 32'h0);
    tick(); master_STB = 1'b0; slave_ACK = '0;

    // ACK from a non-selected slave is ignored
    tick();
    master_STB = 1'b1; master_ADDR = 32'h2000_0000; slave_ACK = 16'h0008;
    #1 check("wrong_ack", {31'h0, master_ACK}, 32'h0);
    tick(); slave_ACK = 16'h0004;
    #1 check("right_ack", {31'h0, master_ACK}, 32'h1);
    tick(); master_STB = 1'b0; slave_ACK = '0;

    // Slave ACK lands on the timeout edge and wins
    tick();
    master_STB = 1'b1; master_ADDR = 32'h5000_0000;
    repeat (TO - 1) tick();
    slave_ACK = 16'h0020;
    #1 check("race_ack", {31'h0, master_ACK}, 32'h1);
    check("race_err", {31'h0, master_ERR}, 32'h0);
    tick(); master_STB = 1'b0; slave_ACK = '0;
    #1 check("race_no_err", {31'h0, master_ERR}, 32'h0);
    check("race_err_addr", err_addr, 32'h9000_0000);

    // Reset mid-cycle, then the access resumes with a fresh count
    tick();
    master_STB = 1'b1; master_ADDR = 32'h3000_0000;
    repeat (3) tick();
    rst = 1'b1; slave_ACK = 16'h0008;
    #1 check("mid_rst_stb", {16'h0, slave_STB}, 32'h0);
    check("mid_rst_ack", {31'h0, master_ACK}, 32'h0);
    tick();
    #1 check("mid_rst_err_addr", err_addr, 32'h0);
    rst = 1'b0; slave_ACK = '0;
    for (int i = 1; i < TO; i++) begin
      tick();
      #1 check("resume_ack", {31'h0, master_ACK}, 32'h0);
      check("resume_stb", {16'h0, slave_STB}, 32'h0000_0008);
    end
    tick();
    #1 check("resume_err", {31'h0, master_ERR}, 32'h1);
    check("resume_err_addr", err_addr, 32'h3000_0000);
    tick(); master_STB = 1'b0;

    // Random traffic, including back-to-back cycles and occasional resets
    stuck = 0;
    repeat (3000) begin
      @(negedge clk);
      done = master_ACK;
      @(posedge clk);
      #1;
      rst   = ($urandom_range(199) == 0);
      stuck = master_STB ? stuck + 1 : 0;
      if (!master_STB || done || stuck > 3 * TO) begin
        master_STB   = (stuck > 3 * TO) ? 1'b0 : ($urandom_range(2) != 0);
        stuck        = 0;
        master_ADDR  = {4'($urandom_range(15)), 28'($urandom)};
        master_WE    = 1'($urandom);
        master_DAT_I = $urandom;
      end
      slave_ACK    = 16'($urandom & $urandom & $urandom);
      slave_ACK[9] = 1'b0;
      for (int k = 0; k < 16; k++) slave_DAT_I[k*32 +: 32] = $urandom;
    end
    rst = 1'b0; master_STB = 1'b0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/wb_bus_intercon.md
Name: wb_bus_intercon

Overview:
- Single-master, 16-slave Wishbone-style interconnect between the multi-cycle CPU (master) and the memory-mapped peripherals (RAM, disk, VRAM, keyboard, counter, …).
- Decodes the master address to a one-hot slave strobe and broadcasts write data, address and WE to all slaves.
- Multiplexes the selected slave's read data and ACK back to the master.
- A bus watchdog terminates cycles to unmapped or hung slaves with an error ACK so the CPU never stalls forever.

Parameters:
- NUM_SLAVES, 16, number of slave ports; fixed at 16 because the decode uses 4 address bits.
- TIMEOUT, 255, cycles the master STB may wait without a slave ACK before the watchdog terminates the cycle; legal range 1..65535.
- ERR_DATA, 32'hDEADBEEF, read data returned on a watchdog-terminated cycle.

Ports:
- clk  input  1  bus clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- master_STB  input  1  master cycle strobe; held high until master_ACK.
- master_WE  input  1  1 = write, 0 = read.
- master_ADDR  input  32  byte address from the master.
- master_DAT_I  input  32  write data from the master.
- master_DAT_O  output  32  read data to the master.
- master_ACK  output  1  cycle-termination pulse to the master.
- master_ERR  output  1  high together with master_ACK when the cycle was ended by the watchdog.
- slave_STB  output  16  one-hot slave strobes.
- slave_ACK  input  16  per-slave acknowledges.
- slave_WE  output  1  broadcast WE.
- slave_ADDR  output  32  broadcast address.
- slave_DAT_O  output  32  broadcast write data.
- slave_DAT_I  input  512  concatenated slave read data; slave k occupies bits [32k+31:32k].
- err_addr  output  32  master_ADDR captured on the most recent watchdog error.

Behaviour:
- Decode: sel = master_ADDR[31:28].
  - slave 0 = 0x0xxxxxxx (RAM)
  - slave 1 = 0x1xxxxxxx
  - … through slave 15 = 0xFxxxxxxx
- Pass-through, purely combinational, no added latency: slave_ADDR = master_ADDR, slave_DAT_O = master_DAT_I, slave_WE = master_WE.
- slave_STB[sel] = master_STB & ~blocked & ~rst; all other slave_STB bits are 0.
- master_DAT_O:
  - equals ERR_DATA in the cycle err_pulse is high;
  - otherwise equals slave_DAT_I[32*sel+31 : 32*sel].
- master_ACK = (master_STB & slave_ACK[sel] & ~blocked & ~rst) | err_pulse.
- ACKs from non-selected slaves are ignored.
- master_ERR = err_pulse.
- Watchdog registers (all clear on rst): wd_cnt (16-bit), err_pulse, blocked, err_addr.
  - master_STB low: wd_cnt ← 0 and blocked ← 0.
  - master_STB high and selected ACK seen: wd_cnt ← 0.
  - master_STB high, no ACK, not blocked, wd_cnt == TIMEOUT-1: err_pulse ← 1 for exactly one cycle, blocked ← 1, err_addr ← master_ADDR, wd_cnt ← 0.
  - master_STB high, no ACK, not blocked, wd_cnt < TIMEOUT-1: wd_cnt increments.
  - While blocked: no slave strobe is driven and wd_cnt holds 0. blocked clears only once master_STB drops.
- Timing: a cycle whose slave never ACKs sees master_ACK/master_ERR exactly TIMEOUT cycles after STB first samples high.
- Simultaneous slave ACK and timeout edge: the slave ACK wins. No err_pulse is generated and the counter resets.
- Back-to-back cycles (STB held high across an ACK with a new address): allowed. The counter restarts at 0 on the ACK cycle.
- Reset mid-cycle:
  - all strobes and master_ACK drop in the reset cycle;
  - counter and blocked clear;
  - err_addr is reset to 0.
- master_ADDR and master_WE must be stable while STB is high. The decode follows the address combinationally, with no latching.

Test Plan:
- Read from RAM: ADDR=0x00000010, STB=1, slave0 ACKs after 3 cycles with DAT=0x12345678 → slave_STB=16'h0001, master_ACK high in that cycle, master_DAT_O=0x12345678, master_ERR=0.
- Write to slave 4: ADDR=0x40000000, WE=1, DAT_I=0xCAFEF00D, slave4 ACKs immediately → slave_STB=16'h0010, slave_WE=1, slave_DAT_O=0xCAFEF00D, master_ACK same cycle.
- Unmapped slave 9 never ACKs, TIMEOUT=8 → master_ACK+master_ERR pulse on cycle 8, master_DAT_O=0xDEADBEEF, err_addr=0x90000000, slave_STB=0 while STB held; after STB drops, a new access to slave 0 completes normally.
- Wrong-slave ACK: ADDR=0x20000000, slave3 asserts ACK → no master_ACK; slave2 ACK later → master_ACK.
- Simultaneous slave ACK and timeout edge (TIMEOUT=4, slave ACKs in cycle 4) → master_ACK=1, master_ERR=0, err_addr unchanged.
- Reset asserted mid-cycle with STB high → slave_STB=0, master_ACK=0 that cycle, err_addr=0; after release the cycle resumes with counter from 0.
